// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct codes, ALU-op classes and ALU control codes.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_dec.sv
// Combinational ALU decoder: turns the controller's ALU-op class plus the
// instruction funct field into the 3-bit ALU operation select.
module alu_dec
    import mips_pkg::*;
(
    input  aluop_t     aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alucontrol_o
);

    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_ADD: alucontrol_o = ALU_ADD;
            ALUOP_SUB: alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alucontrol_o = ALU_ADD;
                    FN_SUB:  alucontrol_o = ALU_SUB;
                    FN_AND:  alucontrol_o = ALU_AND;
                    FN_OR:   alucontrol_o = ALU_OR;
                    FN_SLT:  alucontrol_o = ALU_SLT;
                    default: alucontrol_o = ALU_ADD;
                endcase
            end
            default: alucontrol_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multi_ctrl.sv
// Moore-style control FSM for a multicycle MIPS datapath with optional
// memory wait handling; the ALU decode lives in alu_dec.
module mips_multi_ctrl
    import mips_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic       pcen,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state_o
);

    state_t state_q, state_d;
    state_t outState;
    aluop_t aluOp;
    logic   ready;
    logic   pcWrite, branchEn, branchTaken;
    logic   irWriteRaw, memWriteRaw, regWriteRaw;

    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_RTYPE:       state_d = S_EXECUTE;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:        state_d = S_ADDIEX;
                    OP_J:           state_d = S_JUMP;
                    default:        state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (ready) state_d = S_MEMWB;
            S_MEMWR:   if (ready) state_d = S_FETCH;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Outputs are decoded from FETCH while in reset, with write strobes gated off.
    always_comb begin
        outState    = rst_n ? state_q : S_FETCH;
        iord        = 1'b0;
        memWriteRaw = 1'b0;
        irWriteRaw  = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        regWriteRaw = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        aluOp       = ALUOP_ADD;
        pcWrite     = 1'b0;
        branchEn    = 1'b0;
        case (outState)
            S_FETCH: begin
                alusrcb    = 2'b01;
                irWriteRaw = ready;
                pcWrite    = ready;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWR: begin
                iord        = 1'b1;
                memWriteRaw = 1'b1;
            end
            S_MEMWB: begin
                memtoreg    = 1'b1;
                regWriteRaw = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst      = 1'b1;
                regWriteRaw = 1'b1;
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                aluOp    = ALUOP_SUB;
                pcsrc    = 2'b01;
                branchEn = 1'b1;
            end
            S_ADDIWB: regWriteRaw = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcWrite = 1'b1;
            end
            default: ;
        endcase
    end

    // bne inverts the sense of the zero flag.
    assign branchTaken = branchEn & (zero ^ (op == OP_BNE));

    assign pcen     = rst_n & (pcWrite | branchTaken);
    assign irwrite  = rst_n & irWriteRaw;
    assign memwrite = rst_n & memWriteRaw;
    assign regwrite = rst_n & regWriteRaw;
    assign state_o  = state_q;

    alu_dec u_alu_dec (
        .aluop_i      (aluOp),
        .funct_i      (funct),
        .alucontrol_o (alucontrol)
    );

endmodule

// File: doc/mips_multi_ctrl.md
MIPS_MULTI_CTRL -- requirements
Module: mips_multi_ctrl

Interface
REQ-001 SHALL expose the following parameter: MEM_WAIT_EN, default 1, meaning that 1 honours mem_ready and 0 treats mem_ready as constant 1.
REQ-002 SHALL expose port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL expose port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL expose port op, input, 6 bits: instruction opcode field [31:26] from the instruction register.
REQ-005 SHALL expose port funct, input, 6 bits: instruction funct field [5:0].
REQ-006 SHALL expose port zero, input, 1 bit: ALU zero flag.
REQ-007 SHALL expose port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-008 SHALL expose the following output ports, each 1 bit: iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen.
REQ-009 SHALL expose port alusrcb, output, 2 bits, with encodings:
- 00 = register B
- 01 = constant 4
- 10 = sign-extended immediate
- 11 = immediate shifted left by 2 (branch offset)
REQ-010 SHALL expose port pcsrc, output, 2 bits, with encodings:
- 00 = ALU result
- 01 = ALUOut (branch target)
- 10 = jump address
REQ-011 SHALL expose port alucontrol, output, 3 bits: ALU operation select.
REQ-012 SHALL expose port state_o, output, 4 bits: current state, for debug.

Function
REQ-013 SHALL be a Moore FSM with the following states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-014 SHALL make the following transitions out of FETCH and DECODE:
- FETCH -> DECODE only when mem_ready=1; otherwise hold.
- DECODE by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> EXECUTE
  - 000100 (beq) or 000101 (bne) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other op -> FETCH (no architectural write).
REQ-015 SHALL make the following remaining transitions:
- MEMADR -> MEMRD for lw, MEMWR for sw.
- MEMRD -> MEMWB on mem_ready; otherwise hold.
- MEMWR -> FETCH on mem_ready; otherwise hold.
- EXECUTE -> ALUWB.
- ADDIEX -> ADDIWB.
- MEMWB, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
REQ-016 SHALL drive the following outputs in FETCH, DECODE and MEMADR:
- FETCH: iord=0, alusrca=0, alusrcb=01, ALU add, pcsrc=00; irwrite=1 and pc write=1 only in the cycle mem_ready=1.
- DECODE: alusrca=0, alusrcb=11, ALU add, so the branch target is precomputed into ALUOut.
- MEMADR and ADDIEX: alusrca=1, alusrcb=10, ALU add.
REQ-017 SHALL drive the following outputs in the memory and write-back states:
- MEMRD: iord=1.
- MEMWR: iord=1, memwrite=1 every cycle until mem_ready.
- MEMWB: regdst=0, memtoreg=1, regwrite=1.
- ALUWB: regdst=1, memtoreg=0, regwrite=1.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1.
REQ-018 SHALL drive the following outputs in EXECUTE, BRANCH and JUMP:
- EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct.
- BRANCH: alusrca=1, alusrcb=00, ALU sub, pcsrc=01.
- JUMP: pcsrc=10, pc write=1.
REQ-019 SHALL compute pcen = pcwrite OR (BRANCH AND (zero XOR (op==000101))), i.e. beq taken when zero=1 and bne taken when zero=0.
REQ-020 SHALL drive all outputs not listed for the current state to 0.
REQ-021 SHALL decode alucontrol from aluop as follows:
- aluop 00 -> 010 (add).
- aluop 01 -> 110 (sub).
- aluop 10 by funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - any other funct -> 010.
REQ-022 SHALL sample op and funct only while the instruction register is stable, i.e. after FETCH; the controller itself SHALL NOT latch op or funct.
REQ-023 SHALL, when MEM_WAIT_EN=0, make every state exit without waiting, giving a lw latency of exactly 5 cycles.

Reset
REQ-024 SHALL, when rst_n=0 at a rising clk edge, move the state to FETCH irrespective of the current state, including mid-access in MEMRD or MEMWR.
REQ-025 SHALL, while rst_n=0, force irwrite, pcen, regwrite and memwrite to 0 combinationally; all other outputs take their FETCH values.
REQ-026 SHALL, in the first cycle after rst_n rises, be in FETCH with state_o=0.

Structure
REQ-027 SHALL place the state encodings, opcode constants, aluop codes and alucontrol codes in the shared package mips_pkg.
REQ-028 SHALL place the ALU decode in a single combinational sub-module alu_dec; the FSM and the pcen logic SHALL reside in mips_multi_ctrl.

Verification
REQ-029 SHALL verify lw with op=100011 and mem_ready=1 constantly: state sequence 0,1,2,3,4,0, with regwrite=1 and memtoreg=1 only in state 4.
REQ-030 SHALL verify beq with op=000100, zero=1 in BRANCH: pcen=1 and pcsrc=01; repeat with zero=0: pcen=0. Then bne with zero=0: pcen=1.
REQ-031 SHALL verify DECODE drives alusrcb=11 and alucontrol=010 for every opcode.
REQ-032 SHALL verify memory waits:
- sw with mem_ready held low 3 cycles in MEMWR: memwrite=1 for 4 cycles, then FETCH.
- FETCH with mem_ready low: irwrite=0 and pcen=0.
REQ-033 SHALL verify R-type with funct=101010: alucontrol=111 in EXECUTE, then ALUWB with regdst=1 and regwrite=1.
REQ-034 SHALL verify reset and illegal opcodes:
- rst_n=0 asserted while in MEMWR with memwrite=1: memwrite=0 the same cycle, state 0 next edge.
- op=111111: DECODE -> FETCH with no write strobe asserted.
